mean_reduce_stream: RTL and testbench

//  Parametrised streaming mean reduction over one tensor dimension, for NUM_CH independent channels.

---
 rtl/mean_reduce_pkg.sv | 23 ++
 rtl/seq_udiv.sv | 66 ++++++
 rtl/mean_reduce_stream.sv | 144 ++++++++++++++
 tb/tb_mean_reduce_stream.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mean_reduce_pkg.sv
// Shared state encoding, rounding-mode constants and width helpers for the
// streaming mean reducer.
package mean_reduce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ACC  = 2'd1;
    localparam state_t DIV  = 2'd2;
    localparam state_t OUT  = 2'd3;

    localparam int RND_TRUNC     = 0;
    localparam int RND_HALF_AWAY = 1;

    function automatic int lenWidth(input int maxLen);
        return $clog2(maxLen + 1);
    endfunction

    function automatic int accWidth(input int dataW, input int maxLen);
        return dataW + lenWidth(maxLen);
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider: one quotient bit per cycle, exactly W cycles from
// start_i to done_o; the first iteration happens on the start edge itself.
module seq_udiv #(
    parameter int W     = 45,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [W-1:0]     dividend_i,
    input  logic [W-1:0]     divisor_i,
    output logic [OUT_W-1:0] quotient_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     srcRem, srcQuo;
    logic [W:0]       shifted;
    logic             fits;
    logic [CNT_W-1:0] cnt_q;
    logic             running_q;
    logic             done_q;

    always_comb begin
        srcRem  = start_i ? '0 : rem_q;
        srcQuo  = start_i ? dividend_i : quo_q;
        shifted = {srcRem, srcQuo[W-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        // The remainder never exceeds the divisor, so the low W bits suffice.
        rem_d   = fits ? (shifted[W-1:0] - divisor_i) : shifted[W-1:0];
        quo_d   = {srcQuo[W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i || running_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
            if (start_i) begin
                cnt_q     <= CNT_W'(1);
                running_q <= 1'b1;
            end else if (running_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign quotient_o = quo_q[OUT_W-1:0];
    assign done_o     = done_q;

endmodule

// File: rtl/mean_reduce_stream.sv
// Streaming per-channel mean: accumulate len beats, divide each channel sum by
// len on parallel sequential dividers, then present one result beat.
module mean_reduce_stream
    import mean_reduce_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 4,
    parameter int MAX_LEN  = 4096,
    parameter int RND_MODE = RND_TRUNC,
    parameter int LEN_W    = lenWidth(MAX_LEN),
    parameter int ACC_W    = accWidth(DATA_W, MAX_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     busy
);

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q [NUM_CH];
    logic signed [ACC_W-1:0]   acc_d [NUM_CH];
    logic signed [ACC_W-1:0]   sextIn [NUM_CH];
    logic                      divStarted_q, divStarted_d;
    logic [NUM_CH*DATA_W-1:0]  outData_q, outData_d;
    logic [NUM_CH*DATA_W-1:0]  meanBus;
    logic [LEN_W-1:0]          lenSel;
    logic [ACC_W-1:0]          rndAdd;
    logic [NUM_CH-1:0]         laneDone;
    logic                      divStart;

    // Zero-length vectors behave as length one; oversize requests saturate.
    always_comb begin
        if (cfg_len == '0)
            lenSel = LEN_W'(1);
        else if (cfg_len > LEN_W'(MAX_LEN))
            lenSel = LEN_W'(MAX_LEN);
        else
            lenSel = cfg_len;
    end

    assign rndAdd   = (RND_MODE == RND_HALF_AWAY) ? ACC_W'(len_q >> 1) : '0;
    assign divStart = (state_q == DIV) && !divStarted_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : gLane
        logic [DATA_W-1:0] elem;
        logic              laneNeg;
        logic [ACC_W-1:0]  absAcc;
        logic [ACC_W-1:0]  dividend;
        logic [DATA_W-1:0] quo;

        assign elem      = in_data[c*DATA_W +: DATA_W];
        assign sextIn[c] = {{(ACC_W-DATA_W){elem[DATA_W-1]}}, elem};
        assign laneNeg   = acc_q[c][ACC_W-1];
        assign absAcc    = laneNeg ? (~acc_q[c] + ACC_W'(1)) : acc_q[c];
        assign dividend  = absAcc + rndAdd;

        seq_udiv #(
            .W     (ACC_W),
            .OUT_W (DATA_W)
        ) uDiv (
            .clk        (clk),
            .rst        (rst),
            .start_i    (divStart),
            .dividend_i (dividend),
            .divisor_i  (ACC_W'(len_q)),
            .quotient_o (quo),
            .done_o     (laneDone[c])
        );

        // Sign is reapplied to the magnitude quotient, giving symmetric rounding.
        assign meanBus[c*DATA_W +: DATA_W] = laneNeg ? (~quo + DATA_W'(1)) : quo;
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        divStarted_d = divStarted_q;
        outData_d    = outData_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    len_d        = lenSel;
                    cnt_d        = LEN_W'(1);
                    divStarted_d = 1'b0;
                    for (int c = 0; c < NUM_CH; c++) acc_d[c] = sextIn[c];
                    state_d = (lenSel == LEN_W'(1)) ? DIV : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_q[c] + sextIn[c];
                    if (cnt_q + LEN_W'(1) == len_q) state_d = DIV;
                end
            end
            DIV: begin
                divStarted_d = 1'b1;
                if (divStarted_q && (&laneDone)) begin
                    outData_d    = meanBus;
                    divStarted_d = 1'b0;
                    state_d      = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            divStarted_q <= 1'b0;
            outData_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            divStarted_q <= divStarted_d;
            outData_q    <= outData_d;
            acc_q        <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE) || (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = outData_q;

endmodule

// File: tb/tb_mean_reduce_stream.sv
// Directed bench for mean_reduce_stream: a truncating and a rounding instance
// share the same stimulus; expected means are worked out by hand.
module tb_mean_reduce_stream;

    localparam int DATA_W  = 32;
    localparam int NUM_CH  = 4;
    localparam int MAX_LEN = 4096;
    localparam int LEN_W   = 13;
    localparam int ACC_W   = 45;
    localparam int LATENCY = ACC_W + 1;
    localparam int BUS_W   = NUM_CH * DATA_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [LEN_W-1:0] cfgLen = '0;
    logic             inValid = 1'b0;
    logic [BUS_W-1:0] inData = '0;
    logic             outReady = 1'b1;

    logic             inReadyT, outValidT, busyT;
    logic [BUS_W-1:0] outDataT;
    logic             inReadyR, outValidR, busyR;
    logic [BUS_W-1:0] outDataR;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mean_reduce_stream #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .RND_MODE(0)
    ) dutT (
        .clk(clk), .rst(rst), .cfg_len(cfgLen), .in_valid(inValid), .in_ready(inReadyT),
        .in_data(inData), .out_valid(outValidT), .out_ready(outReady), .out_data(outDataT),
        .busy(busyT)
    );

    mean_reduce_stream #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .RND_MODE(1)
    ) dutR (
        .clk(clk), .rst(rst), .cfg_len(cfgLen), .in_valid(inValid), .in_ready(inReadyR),
        .in_data(inData), .out_valid(outValidR), .out_ready(outReady), .out_data(outDataR),
        .busy(busyR)
    );

    function automatic logic [BUS_W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic applyStimulus(input int len, input logic [BUS_W-1:0] data);
        cfgLen  = LEN_W'(len);
        inData  = data;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    // Returns the number of edges until a result appears, or -1 on timeout.
    task automatic waitOut(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (outValidT || outValidR) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({outValidT, busyT, inReadyT, outValidR, busyR, inReadyR} !== 6'b001001) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=001001",
                     {outValidT, busyT, inReadyT, outValidR, busyR, inReadyR});
        end
        checks++;
        if ({outDataT, outDataR} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h exp=0", outDataT, outDataR);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_mean();
        int cyc;
        applyStimulus(4, pack4(1, -5, 100, -3));
        applyStimulus(4, pack4(2, -5, 0, 0));
        applyStimulus(4, pack4(3, -5, 0, 0));
        applyStimulus(4, pack4(4, -5, 1, 0));
        checks++;
        if ({busyT, inReadyT, busyR, inReadyR} !== 4'b1010) begin
            failures++;
            $display("[TB] FAIL basic_div_flags got=%b exp=1010", {busyT, inReadyT, busyR, inReadyR});
        end
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY || !(outValidT && outValidR)) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d (vT=%b vR=%b) exp=%0d", cyc, outValidT, outValidR, LATENCY);
        end
        checks++;
        if (outDataT !== pack4(2, -5, 25, 0)) begin
            failures++;
            $display("[TB] FAIL basic_trunc got=%h exp=%h", outDataT, pack4(2, -5, 25, 0));
        end
        checks++;
        if (outDataR !== pack4(3, -5, 25, -1)) begin
            failures++;
            $display("[TB] FAIL basic_round got=%h exp=%h", outDataR, pack4(3, -5, 25, -1));
        end
        @(posedge clk); #1;
        checks++;
        if (outValidT !== 1'b0 || outValidR !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_valid_drop got=%b%b exp=00", outValidT, outValidR);
        end
    endtask

    task automatic test_neg_rounding();
        int cyc;
        applyStimulus(3, pack4(-1, 1, 2, -4));
        applyStimulus(3, pack4(-1, 1, 2, -4));
        applyStimulus(3, pack4(0, 0, 1, -4));
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL neg_latency got=%0d exp=%0d", cyc, LATENCY);
        end
        checks++;
        if (outDataT !== pack4(0, 0, 1, -4)) begin
            failures++;
            $display("[TB] FAIL neg_trunc got=%h exp=%h", outDataT, pack4(0, 0, 1, -4));
        end
        checks++;
        if (outDataR !== pack4(-1, 1, 2, -4)) begin
            failures++;
            $display("[TB] FAIL neg_round got=%h exp=%h", outDataR, pack4(-1, 1, 2, -4));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_max_len();
        int cyc;
        logic [BUS_W-1:0] expPos;
        logic [BUS_W-1:0] expNeg;
        expPos = {NUM_CH{32'h7FFF_FFFF}};
        expNeg = {NUM_CH{32'h8000_0000}};
        // An oversize length must clamp to MAX_LEN, otherwise no result appears.
        for (int i = 0; i < MAX_LEN; i++) applyStimulus(8191, expPos);
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL maxpos_latency got=%0d exp=%0d", cyc, LATENCY);
        end
        checks++;
        if (outDataT !== expPos || outDataR !== expPos) begin
            failures++;
            $display("[TB] FAIL maxpos_data got=%h/%h exp=%h", outDataT, outDataR, expPos);
        end
        @(posedge clk); #1;
        for (int i = 0; i < MAX_LEN; i++) applyStimulus(MAX_LEN, expNeg);
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL maxneg_latency got=%0d exp=%0d", cyc, LATENCY);
        end
        checks++;
        if (outDataT !== expNeg || outDataR !== expNeg) begin
            failures++;
            $display("[TB] FAIL maxneg_data got=%h/%h exp=%h", outDataT, outDataR, expNeg);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_config();
        int cyc;
        applyStimulus(0, pack4(7, -7, 0, 100));
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY || outDataT !== pack4(7, -7, 0, 100) || outDataR !== pack4(7, -7, 0, 100)) begin
            failures++;
            $display("[TB] FAIL len0 got=%0d %h/%h exp=%0d %h", cyc, outDataT, outDataR, LATENCY, pack4(7, -7, 0, 100));
        end
        @(posedge clk); #1;
        applyStimulus(1, pack4(7, -7, 0, 100));
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY || outDataT !== pack4(7, -7, 0, 100) || outDataR !== pack4(7, -7, 0, 100)) begin
            failures++;
            $display("[TB] FAIL len1 got=%0d %h/%h exp=%0d %h", cyc, outDataT, outDataR, LATENCY, pack4(7, -7, 0, 100));
        end
        @(posedge clk); #1;
        applyStimulus(2, pack4(10, 4, -6, 0));
        applyStimulus(5, pack4(20, 5, -7, 1));
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL cfg_change_latency got=%0d exp=%0d", cyc, LATENCY);
        end
        checks++;
        if (outDataT !== pack4(15, 4, -6, 0) || outDataR !== pack4(15, 5, -7, 1)) begin
            failures++;
            $display("[TB] FAIL cfg_change_data got=%h/%h exp=%h/%h", outDataT, outDataR,
                     pack4(15, 4, -6, 0), pack4(15, 5, -7, 1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [BUS_W-1:0] expHeld;
        expHeld  = pack4(3, -3, 11, -11);
        outReady = 1'b0;
        applyStimulus(1, expHeld);
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL bp_latency got=%0d exp=%0d", cyc, LATENCY);
        end
        inValid = 1'b1;
        inData  = pack4(99, 99, 99, 99);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (!(outValidT && outValidR) || inReadyT || inReadyR || outDataT !== expHeld || outDataR !== expHeld) begin
                failures++;
                $display("[TB] FAIL bp_hold cyc=%0d got v=%b%b rdy=%b%b %h/%h exp v=11 rdy=00 %h",
                         i, outValidT, outValidR, inReadyT, inReadyR, outDataT, outDataR, expHeld);
            end
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({outValidT, inReadyT, outValidR, inReadyR} !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL bp_release got=%b exp=0101", {outValidT, inReadyT, outValidR, inReadyR});
        end
        applyStimulus(1, pack4(9, 8, 7, 6));
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY || outDataT !== pack4(9, 8, 7, 6) || outDataR !== pack4(9, 8, 7, 6)) begin
            failures++;
            $display("[TB] FAIL bp_next got=%0d %h/%h exp=%0d %h", cyc, outDataT, outDataR, LATENCY, pack4(9, 8, 7, 6));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midvector();
        int cyc;
        applyStimulus(8, pack4(1000, 1000, 1000, 1000));
        applyStimulus(8, pack4(1000, 1000, 1000, 1000));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({outValidT, busyT, inReadyT, outValidR, busyR, inReadyR} !== 6'b001001 || {outDataT, outDataR} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_state got=%b %h/%h exp=001001 0",
                     {outValidT, busyT, inReadyT, outValidR, busyR, inReadyR}, outDataT, outDataR);
        end
        applyStimulus(2, pack4(10, -10, 1, 0));
        applyStimulus(2, pack4(20, -20, 2, -1));
        waitOut(cyc);
        checks++;
        if (cyc !== LATENCY) begin
            failures++;
            $display("[TB] FAIL midreset_latency got=%0d exp=%0d", cyc, LATENCY);
        end
        checks++;
        if (outDataT !== pack4(15, -15, 1, 0) || outDataR !== pack4(15, -15, 2, -1)) begin
            failures++;
            $display("[TB] FAIL midreset_data got=%h/%h exp=%h/%h", outDataT, outDataR,
                     pack4(15, -15, 1, 0), pack4(15, -15, 2, -1));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_mean();
        test_neg_rounding();
        test_max_len();
        test_len_config();
        test_backpressure();
        test_reset_midvector();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
